// File: rtl/udp_perf_pkg.sv
// Shared constants for the perf-test packet generator/checker pair:
// header layout, error-code bit positions, FSM encoding and counter limits.
package udp_perf_pkg;

  localparam int SEQ_LSB     = 0;
  localparam int LEN_LSB     = 32;
  localparam int MIN_PKT_LEN = 8;

  localparam int ERR_LEN     = 0;
  localparam int ERR_PAYLOAD = 1;
  localparam int ERR_SEQ     = 2;
  localparam int ERR_TUSER   = 3;

  localparam logic [0:0] S_HDR  = 1'b0;
  localparam logic [0:0] S_BODY = 1'b1;

  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/axis_keep_check.sv
// Combinational tkeep helper: byte count of a beat and a check that the set
// bits form one contiguous run starting at bit 0.
module axis_keep_check #(
  parameter int KEEP_WIDTH = 64,
  parameter int CNT_W      = $clog2(KEEP_WIDTH + 1)
) (
  input  logic [KEEP_WIDTH-1:0] keep,
  output logic [CNT_W-1:0]      byte_cnt,
  output logic                  contiguous
);

  logic [KEEP_WIDTH-1:0] keep_inc;

  // A low run of ones is the only pattern where +1 clears every set bit.
  assign keep_inc   = keep + KEEP_WIDTH'(1);
  assign contiguous = ((keep & keep_inc) == '0);

  always_comb begin
    byte_cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      byte_cnt = byte_cnt + CNT_W'(keep[i]);
    end
  end

endmodule

// File: rtl/udp_perf_pkt_checker.sv
// Receive-side checker for the CMAC loop perf test: parses the perf header,
// verifies sequence, length and payload pattern, and keeps throughput counters.
module udp_perf_pkt_checker
  import udp_perf_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [CNT_WIDTH-1:0]  recv_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  err_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  seq_gap_cnt,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic                  cycle_cnt_full,
  output logic                  first_pkt_seen,
  output logic                  pkt_done,
  output logic                  pkt_err,
  output logic [3:0]            err_code
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam int BC_W  = $clog2(KEEP_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] SAT = CNT_SAT[CNT_WIDTH-1:0];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == SAT) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic                 tready_reg;
  logic [0:0]           state_reg;
  logic [31:0]          seq_reg, len_reg, byte_sum_reg, exp_seq_reg;
  logic                 cnt_en_reg, first_seen_reg;
  logic [15:0]          beat_idx_reg;
  logic [3:0]           err_acc_reg, err_code_reg;
  logic                 done_reg, pkt_err_reg, cycle_full_reg;
  logic [CNT_WIDTH-1:0] recv_reg, err_pkt_reg, gap_reg, beat_cnt_reg, cycle_reg;

  logic             accept, is_hdr, cur_cnt_en, seq_gap, keep_contig;
  logic [31:0]      cur_seq, cur_len, exp_word, byte_sum_next;
  logic [BC_W-1:0]  beat_bytes;
  logic [LANES-1:0] lane_bad;
  logic [3:0]       beat_err, err_next;

  assign accept     = s_axis_tvalid && tready_reg;
  assign is_hdr     = (state_reg == S_HDR);
  assign cur_seq    = is_hdr ? s_axis_tdata[SEQ_LSB +: 32] : seq_reg;
  assign cur_len    = is_hdr ? s_axis_tdata[LEN_LSB +: 32] : len_reg;
  assign cur_cnt_en = is_hdr ? enable : cnt_en_reg;
  assign exp_word   = seq_reg + {16'h0000, beat_idx_reg};
  assign seq_gap    = is_hdr && enable && first_seen_reg && (cur_seq != exp_seq_reg);

  axis_keep_check #(.KEEP_WIDTH(KEEP_WIDTH)) u_keep_check (
    .keep       (s_axis_tkeep),
    .byte_cnt   (beat_bytes),
    .contiguous (keep_contig)
  );

  // Only lanes carrying all four bytes take part in the payload compare.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_bad[gi] = (&s_axis_tkeep[4*gi +: 4]) &&
                          (s_axis_tdata[32*gi +: 32] != exp_word);
  end

  always_comb begin
    beat_err          = '0;
    beat_err[ERR_LEN] = s_axis_tlast ? !keep_contig : (s_axis_tkeep != '1);
    if (is_hdr) begin
      if (s_axis_tkeep[7:0] != 8'hFF) beat_err[ERR_LEN] = 1'b1;
      beat_err[ERR_SEQ] = seq_gap;
    end else begin
      beat_err[ERR_PAYLOAD] = |lane_bad;
    end
    beat_err[ERR_TUSER] = s_axis_tuser[0];
    byte_sum_next = (is_hdr ? 32'd0 : byte_sum_reg) + 32'(beat_bytes);
    if (s_axis_tlast && ((byte_sum_next != cur_len) || (cur_len < 32'(MIN_PKT_LEN))))
      beat_err[ERR_LEN] = 1'b1;
    err_next = (is_hdr ? 4'd0 : err_acc_reg) | beat_err;
  end

  // Packet parse; clear deliberately leaves this path alone.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tready_reg   <= 1'b0;
      state_reg    <= S_HDR;
      seq_reg      <= '0;
      len_reg      <= '0;
      cnt_en_reg   <= 1'b0;
      beat_idx_reg <= '0;
      byte_sum_reg <= '0;
      err_acc_reg  <= '0;
      done_reg     <= 1'b0;
      pkt_err_reg  <= 1'b0;
      err_code_reg <= '0;
    end else begin
      tready_reg <= 1'b1;
      done_reg   <= 1'b0;
      if (accept) begin
        err_acc_reg  <= err_next;
        byte_sum_reg <= byte_sum_next;
        state_reg    <= s_axis_tlast ? S_HDR : S_BODY;
        if (is_hdr) begin
          seq_reg      <= cur_seq;
          len_reg      <= cur_len;
          cnt_en_reg   <= enable;
          beat_idx_reg <= 16'd1;
        end else if (beat_idx_reg != 16'hFFFF) begin
          beat_idx_reg <= beat_idx_reg + 16'd1;
        end
        if (s_axis_tlast) begin
          done_reg     <= 1'b1;
          pkt_err_reg  <= |err_next;
          err_code_reg <= err_next;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      recv_reg       <= '0;
      err_pkt_reg    <= '0;
      gap_reg        <= '0;
      beat_cnt_reg   <= '0;
      cycle_reg      <= '0;
      cycle_full_reg <= 1'b0;
      first_seen_reg <= 1'b0;
      exp_seq_reg    <= '0;
    end else if (clear) begin
      recv_reg       <= '0;
      err_pkt_reg    <= '0;
      gap_reg        <= '0;
      beat_cnt_reg   <= '0;
      cycle_reg      <= '0;
      cycle_full_reg <= 1'b0;
      first_seen_reg <= 1'b0;
      exp_seq_reg    <= '0;
    end else begin
      if (first_seen_reg) begin
        cycle_reg <= sat_inc(cycle_reg);
        if (sat_inc(cycle_reg) == SAT) cycle_full_reg <= 1'b1;
      end
      if (accept && cur_cnt_en) beat_cnt_reg <= sat_inc(beat_cnt_reg);
      if (accept && is_hdr && enable) begin
        first_seen_reg <= 1'b1;
        exp_seq_reg    <= cur_seq + 32'd1;
        if (seq_gap) gap_reg <= sat_inc(gap_reg);
      end
      if (accept && s_axis_tlast && cur_cnt_en) begin
        recv_reg <= sat_inc(recv_reg);
        if (|err_next) err_pkt_reg <= sat_inc(err_pkt_reg);
      end
    end
  end

  assign s_axis_tready  = tready_reg;
  assign recv_pkt_cnt   = recv_reg;
  assign err_pkt_cnt    = err_pkt_reg;
  assign seq_gap_cnt    = gap_reg;
  assign beat_cnt       = beat_cnt_reg;
  assign cycle_cnt      = cycle_reg;
  assign cycle_cnt_full = cycle_full_reg;
  assign first_pkt_seen = first_seen_reg;
  assign pkt_done       = done_reg;
  assign pkt_err        = pkt_err_reg;
  assign err_code       = err_code_reg;

endmodule

// File: tb/tb_udp_perf_pkt_checker.sv
// Bench for udp_perf_pkt_checker: directed vector table, randomized packets
// against a packet-level reference model, plus reset and saturation sequences.
module tb_udp_perf_pkt_checker;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0, clear = 1'b0;
  logic         tvalid = 1'b0, tlast = 1'b0;
  logic [0:0]   tuser = 1'b0;
  logic [511:0] tdata = '0;
  logic [63:0]  tkeep = '0;
  logic         tready, full, first, done, perr;
  logic [31:0]  recv, errp, gap, beats, cyc;
  logic [3:0]   ecode;

  logic         sat_enable = 1'b0, sat_clear = 1'b0, sat_tvalid = 1'b0, sat_tlast = 1'b0;
  logic [0:0]   sat_tuser = 1'b0;
  logic [511:0] sat_tdata = '0;
  logic [63:0]  sat_tkeep = '0;
  logic         sat_tready, sat_full, sat_first, sat_done, sat_perr;
  logic [7:0]   sat_recv, sat_errp, sat_gap, sat_beats, sat_cyc;
  logic [3:0]   sat_ecode;

  always #5 clk = ~clk;

  udp_perf_pkt_checker u_dut (
    .CLK(clk), .RST_N(rst_n), .enable(enable), .clear(clear),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata),
    .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .recv_pkt_cnt(recv), .err_pkt_cnt(errp), .seq_gap_cnt(gap), .beat_cnt(beats),
    .cycle_cnt(cyc), .cycle_cnt_full(full), .first_pkt_seen(first),
    .pkt_done(done), .pkt_err(perr), .err_code(ecode)
  );

  udp_perf_pkt_checker #(.CNT_WIDTH(8)) u_sat (
    .CLK(clk), .RST_N(rst_n), .enable(sat_enable), .clear(sat_clear),
    .s_axis_tvalid(sat_tvalid), .s_axis_tready(sat_tready), .s_axis_tdata(sat_tdata),
    .s_axis_tkeep(sat_tkeep), .s_axis_tlast(sat_tlast), .s_axis_tuser(sat_tuser),
    .recv_pkt_cnt(sat_recv), .err_pkt_cnt(sat_errp), .seq_gap_cnt(sat_gap),
    .beat_cnt(sat_beats), .cycle_cnt(sat_cyc), .cycle_cnt_full(sat_full),
    .first_pkt_seen(sat_first), .pkt_done(sat_done), .pkt_err(sat_perr),
    .err_code(sat_ecode)
  );

  int checks = 0, failures = 0;
  int n_pkts = 0, done_seen = 0;

  // reference model state
  int unsigned m_recv, m_errp, m_gap, m_beats;
  logic        m_first;
  logic [31:0] m_exp;
  longint      t0;

  logic [511:0] bd[$];
  logic [63:0]  bk[$];
  logic         bu[$];

  typedef struct {
    logic [31:0] seq;
    int          len;
    int          nbytes;
    int          corrupt;
    logic [3:0]  exp_err;
    string       name;
  } vec_t;
  vec_t vecs[10];

  always @(negedge clk) if (done) done_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] low_mask(input int n);
    return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
  endfunction

  task automatic model_clear();
    m_recv = 0; m_errp = 0; m_gap = 0; m_beats = 0; m_first = 1'b0; m_exp = '0;
  endtask

  task automatic build_pkt(input logic [31:0] s, input int ln, input int nb);
    int n = (nb + 63) / 64;
    bd.delete(); bk.delete(); bu.delete();
    for (int k = 0; k < n; k++) begin
      logic [511:0] d;
      logic [63:0]  kp;
      int           rem;
      rem = (k == n - 1) ? nb - 64 * k : 64;
      kp  = low_mask(rem);
      for (int j = 0; j < 16; j++) begin
        if (k == 0 || kp[4*j+3] == 1'b0) d[32*j +: 32] = $urandom;
        else d[32*j +: 32] = s + 32'(k);
      end
      if (k == 0) begin
        d[31:0]  = s;
        d[63:32] = 32'(ln);
      end
      bd.push_back(d); bk.push_back(kp); bu.push_back(1'b0);
    end
  endtask

  // Expected error code straight from the packet rules, before the model advances.
  function automatic logic [3:0] model_err(input logic counted);
    logic [3:0]   e = 4'd0;
    logic [511:0] h = bd[0];
    logic [31:0]  s = h[31:0];
    logic [31:0]  l = h[63:32];
    int           total = 0;
    int           n = bd.size();
    for (int k = 0; k < n; k++) begin
      logic [511:0] d = bd[k];
      logic [63:0]  kp = bk[k];
      int           ones = $countones(kp);
      total += ones;
      if (k < n - 1 && ones != 64) e[0] = 1'b1;
      if (k == n - 1 && kp != low_mask(ones)) e[0] = 1'b1;
      if (bu[k]) e[3] = 1'b1;
      if (k > 0)
        for (int j = 0; j < 16; j++)
          if (kp[4*j +: 4] == 4'hF && d[32*j +: 32] != s + 32'(k)) e[1] = 1'b1;
    end
    if (h[7:0] !== h[7:0] || bk[0][7:0] != 8'hFF) e[0] = 1'b1;
    if (32'(total) != l || l < 32'd8) e[0] = 1'b1;
    if (counted && m_first && s != m_exp) e[2] = 1'b1;
    return e;
  endfunction

  task automatic apply_corrupt(input int kind);
    logic [511:0] d;
    logic [63:0]  kp;
    case (kind)
      1: begin d = bd[1]; d[32*3 +: 32] = d[32*3 +: 32] ^ 32'h0000_0100; bd[1] = d; end
      2: bu[1] = 1'b1;
      3: begin kp = bk[1]; kp[63] = 1'b0; bk[1] = kp; end
      default: ;
    endcase
  endtask

  task automatic run_pkt(input logic en, input logic drop_en, input logic clr_last,
                         input logic bubbles, input logic [3:0] exp_err, input string name);
    int           n = bd.size();
    logic [511:0] h = bd[0];
    logic [31:0]  s = h[31:0];
    for (int k = 0; k < n; k++) begin
      if (bubbles && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      tvalid = 1'b1; tdata = bd[k]; tkeep = bk[k]; tuser = bu[k]; tlast = (k == n - 1);
      enable = (k == 0) ? en : (en && !drop_en);
      clear  = clr_last && (k == n - 1);
      @(negedge clk);
      if (k == 0 && en && !m_first) t0 = $time - 5;
      tvalid = 1'b0; tlast = 1'b0; clear = 1'b0; tuser = 1'b0;
    end
    n_pkts++;
    $display("PKT %s seq=%08h beats=%0d en=%0b err_code=%04b expected=%04b",
             name, s, n, en, ecode, exp_err);
    chk({name, "_done"}, 64'(done), 64'd1);
    chk({name, "_err_code"}, 64'(ecode), 64'(exp_err));
    chk({name, "_pkt_err"}, 64'(perr), 64'(|exp_err));
    if (clr_last) model_clear();
    else if (en) begin
      m_recv++;
      if (exp_err != 4'd0) m_errp++;
      m_beats += n;
      if (m_first && s != m_exp) m_gap++;
      m_first = 1'b1;
      m_exp   = s + 32'd1;
    end
  endtask

  task automatic check_counters(input string name);
    chk({name, "_recv"}, 64'(recv), 64'(m_recv));
    chk({name, "_errp"}, 64'(errp), 64'(m_errp));
    chk({name, "_gap"}, 64'(gap), 64'(m_gap));
    chk({name, "_beats"}, 64'(beats), 64'(m_beats));
    chk({name, "_first"}, 64'(first), 64'(m_first));
    chk({name, "_cycles"}, 64'(cyc), m_first ? 64'(($time - t0) / 10) : 64'd0);
    chk({name, "_full"}, 64'(full), 64'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
  endtask

  initial begin
    vecs[0] = '{32'd5,          200, 200, 0, 4'b0000, "good_200"};
    vecs[1] = '{32'd6,           64,  64, 0, 4'b0000, "good_64"};
    vecs[2] = '{32'hFFFF_FFFF,   64,  64, 0, 4'b0000, "wrap_a"};
    vecs[3] = '{32'd0,           64,  64, 0, 4'b0000, "wrap_b"};
    vecs[4] = '{32'd3,           64,  64, 0, 4'b0100, "gap"};
    vecs[5] = '{32'd4,          128, 128, 1, 4'b0010, "payload"};
    vecs[6] = '{32'd5,          130, 128, 0, 4'b0001, "short"};
    vecs[7] = '{32'd6,          192, 192, 2, 4'b1000, "tuser"};
    vecs[8] = '{32'd7,          192, 192, 3, 4'b0001, "keep"};
    vecs[9] = '{32'd8,          100, 100, 0, 4'b0000, "good_after"};
    model_clear();
    t0 = 0;

    repeat (2) @(negedge clk);
    chk("rst_cnts", 64'(recv | errp | gap | beats | cyc), 64'd0);
    chk("rst_flags", 64'({tready, full, first, done, perr, ecode}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_up", 64'(tready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      build_pkt(vecs[i].seq, vecs[i].len, vecs[i].nbytes);
      apply_corrupt(vecs[i].corrupt);
      run_pkt(1'b1, 1'b0, 1'b0, 1'b0, vecs[i].exp_err, vecs[i].name);
      if (i == 1) begin
        chk("good_recv", 64'(recv), 64'd2);
        chk("good_errp", 64'(errp), 64'd0);
        chk("good_gap", 64'(gap), 64'd0);
        chk("good_beats", 64'(beats), 64'd5);
        do_clear();
        check_counters("after_clear");
      end
    end
    chk("dir_recv", 64'(recv), 64'd8);
    chk("dir_errp", 64'(errp), 64'd5);
    chk("dir_gap", 64'(gap), 64'd1);
    chk("dir_beats", 64'(beats), 64'd15);
    check_counters("dir_model");

    build_pkt(32'd9, 192, 192);
    run_pkt(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, "en_drop");
    check_counters("en_drop");
    build_pkt(32'd10, 128, 128);
    run_pkt(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "clr_on_last");
    @(negedge clk);
    chk("clr_recv", 64'(recv), 64'd0);
    check_counters("clr_on_last");
    build_pkt(32'd77, 64, 64);
    run_pkt(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "not_counted");
    check_counters("not_counted");

    for (int p = 0; p < 40; p++) begin
      logic [31:0]  s;
      logic [511:0] d;
      logic [63:0]  kp;
      int           nb, ln, kind, k, j, b;
      logic         en, drop;
      en   = ($urandom_range(0, 9) != 0);
      s    = (m_first && $urandom_range(0, 7) != 0) ? m_exp : $urandom;
      nb   = $urandom_range(8, 300);
      ln   = ($urandom_range(0, 9) == 0) ? nb + $urandom_range(1, 5) : nb;
      build_pkt(s, ln, nb);
      kind = $urandom_range(0, 5);
      if (kind == 3 && bd.size() > 1) begin
        k = $urandom_range(1, bd.size() - 1); j = $urandom_range(0, 15);
        d = bd[k]; d[32*j +: 32] = d[32*j +: 32] ^ (32'd1 << $urandom_range(0, 31)); bd[k] = d;
      end else if (kind == 4) begin
        bu[$urandom_range(0, bd.size() - 1)] = 1'b1;
      end else if (kind == 5) begin
        k = $urandom_range(0, bd.size() - 1); b = $urandom_range(0, 63);
        kp = bk[k]; kp[b] = ~kp[b]; bk[k] = kp;
      end
      drop = ($urandom_range(0, 4) == 0);
      run_pkt(en, drop, 1'b0, 1'b1, model_err(en), $sformatf("rnd%0d", p));
      if (p % 10 == 9) check_counters($sformatf("rnd_cnt%0d", p));
    end

    build_pkt(32'd20, 256, 256);
    for (int k = 0; k < 2; k++) begin
      tvalid = 1'b1; tdata = bd[k]; tkeep = bk[k]; tlast = 1'b0; enable = 1'b1;
      @(negedge clk);
    end
    tvalid = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_cnts", 64'(recv | errp | gap | beats | cyc), 64'd0);
    chk("midrst_flags", 64'({tready, full, first, done, perr, ecode}), 64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_tready_lo", 64'(tready), 64'd0);
    @(negedge clk);
    chk("rel_tready_hi", 64'(tready), 64'd1);
    build_pkt(32'd50, 100, 100);
    run_pkt(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, "post_reset");
    check_counters("post_reset");

    sat_tdata = '0; sat_tdata[31:0] = 32'd1; sat_tdata[63:32] = 32'd64;
    sat_tkeep = '1; sat_tlast = 1'b1; sat_enable = 1'b1; sat_tvalid = 1'b1;
    @(negedge clk);
    sat_tvalid = 1'b0;
    chk("sat_first", 64'(sat_first), 64'd1);
    repeat (254) @(negedge clk);
    chk("sat_cyc_254", 64'(sat_cyc), 64'd254);
    chk("sat_full_pre", 64'(sat_full), 64'd0);
    @(negedge clk);
    chk("sat_cyc_255", 64'(sat_cyc), 64'd255);
    chk("sat_full", 64'(sat_full), 64'd1);
    repeat (5) @(negedge clk);
    chk("sat_cyc_hold", 64'(sat_cyc), 64'd255);
    chk("sat_full_hold", 64'(sat_full), 64'd1);
    chk("sat_recv", 64'(sat_recv), 64'd1);

    chk("done_pulses", 64'(done_seen), 64'(n_pkts));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
